// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key-schedule blocks.
// Key matrices are [row][col] bytes; column c is one 32-bit word.
package aes_pkg;

    localparam int NUM_ROUNDS_128 = 10;

    typedef logic [3:0][3:0][7:0] key_mat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_XOR,
        ST_SUB
    } ks_state_t;

    // Round constant that turns round key idx into round key idx-1.
    function automatic logic [7:0] rcon_f(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_sbox_word.sv
// Four parallel forward AES S-box lookups on one 32-bit word.
// Shared by the forward and inverse key expanders.
module aes_key_sbox_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    // Byte x of the table sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        logic [7:0] w_in;
        assign w_in = i_word[8*b +: 8];
        assign o_word[8*b +: 8] = SBOX[2047 - 8*int'(w_in) -: 8];
    end

endmodule

// File: rtl/aes_inv_key_expander.sv
// AES-128 backward key schedule: loads round-10 key and streams
// round keys 10..0 over valid/ready, rebuilding each on the fly.
module aes_inv_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH  = 128,
    parameter int NUM_ROUNDS = NUM_ROUNDS_128
) (
    input  logic       clk,
    input  logic       reset,
    input  key_mat_t   final_key,
    input  logic       key_load,
    output logic       load_rdy,
    output logic       rk_valid,
    input  logic       rk_ready,
    output key_mat_t   round_key,
    output logic [3:0] round_idx,
    output logic       sched_done
);

    if (KEY_WIDTH != 128) begin : g_bad_width
        $error("aes_inv_key_expander supports only KEY_WIDTH=128");
    end

    ks_state_t  r_state;
    key_mat_t   r_key;
    logic [3:0] r_idx;
    logic       r_load_rdy;
    logic       r_valid;
    logic       r_done;

    key_mat_t    w_key_xor;
    key_mat_t    w_key_sub;
    logic [31:0] w_col3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_col0;
    logic [31:0] w_new0;

    // In SUB_STEP r_key already holds the XOR-stepped words 1..3.
    assign w_col3 = {r_key[0][3], r_key[1][3], r_key[2][3], r_key[3][3]};
    assign w_col0 = {r_key[0][0], r_key[1][0], r_key[2][0], r_key[3][0]};
    assign w_rot  = {w_col3[23:0], w_col3[31:24]};

    aes_key_sbox_word u_sbox (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_new0 = w_col0 ^ w_sub ^ {rcon_f(r_idx), 24'h000000};

    always_comb begin
        w_key_xor = r_key;
        w_key_sub = r_key;
        for (int r = 0; r < 4; r++) begin
            for (int c = 1; c < 4; c++) begin
                w_key_xor[r][c] = r_key[r][c] ^ r_key[r][c-1];
            end
            w_key_sub[r][0] = w_new0[31-8*r -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_key      <= '0;
            r_idx      <= '0;
            r_load_rdy <= 1'b1;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (key_load) begin
                        r_key      <= final_key;
                        r_idx      <= 4'(NUM_ROUNDS);
                        r_valid    <= 1'b1;
                        r_load_rdy <= 1'b0;
                        r_state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (rk_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == 4'd0) begin
                            r_load_rdy <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_XOR;
                        end
                    end
                end
                ST_XOR: begin
                    r_key   <= w_key_xor;
                    r_state <= ST_SUB;
                end
                ST_SUB: begin
                    r_key   <= w_key_sub;
                    r_idx   <= r_idx - 4'd1;
                    r_valid <= 1'b1;
                    r_state <= ST_PRESENT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign load_rdy   = r_load_rdy;
    assign rk_valid   = r_valid;
    assign round_key  = r_key;
    assign round_idx  = r_idx;
    assign sched_done = r_done;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
// Bench for the backward key schedule: reference round keys come from
// a forward FIPS-197 expansion with an arithmetically derived S-box.
module tb_aes_inv_key_expander;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    key_mat_t   final_key = '0;
    logic       key_load = 1'b0;
    logic       load_rdy;
    logic       rk_valid;
    logic       rk_ready = 1'b0;
    key_mat_t   round_key;
    logic [3:0] round_idx;
    logic       sched_done;

    int errs = 0;
    int checks = 0;

    logic [7:0] sb [256];
    key_mat_t   exp_rk [11];

    aes_inv_key_expander #(
        .KEY_WIDTH  (128),
        .NUM_ROUNDS (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .final_key  (final_key),
        .key_load   (key_load),
        .load_rdy   (load_rdy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .sched_done (sched_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic key_mat_t to_mat(input logic [127:0] ws);
        key_mat_t m;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = ws[127 - 32*c - 8*r -: 8];
        return m;
    endfunction

    task automatic build_expected(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++)
            exp_rk[k] = to_mat({w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]});
    endtask

    // Runs one full schedule; pct is the chance rk_ready is offered.
    task automatic run_sched(input string name, input key_mat_t fk,
                             input int pct, input bit poke);
        int  e, wait_n, total;
        bit  done, fresh, timed_out;
        @(negedge clk);
        chk({name, " load_rdy_idle"}, 128'(load_rdy), 128'(1));
        final_key = fk;
        key_load  = 1'b1;
        rk_ready  = 1'b0;
        e = 10; wait_n = 0; total = 0;
        done = 0; fresh = 1; timed_out = 0;
        while (!done) begin
            @(negedge clk);
            wait_n++;
            total++;
            key_load  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            final_key = poke ? to_mat({$urandom, $urandom, $urandom, $urandom}) : fk;
            if (wait_n > 100) begin
                chk({name, " timeout_valid"}, 128'(rk_valid), 128'(1));
                timed_out = 1;
                done = 1;
            end else if (rk_valid) begin
                if (fresh)
                    chk($sformatf("%s lat_idx%0d", name, e), 128'(wait_n),
                        128'(e == 10 ? 1 : 3));
                fresh = 0;
                chk($sformatf("%s key_idx%0d", name, e), round_key, exp_rk[e]);
                chk($sformatf("%s idx%0d", name, e), 128'(round_idx), 128'(e));
                chk({name, " load_rdy_busy"}, 128'(load_rdy), 128'(0));
                rk_ready = ($urandom_range(0, 99) < pct);
                if (rk_ready) begin
                    if (e == 0) begin
                        key_load = poke;
                        done = 1;
                    end else begin
                        e--;
                        wait_n = 0;
                        fresh = 1;
                    end
                end
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
                chk({name, " load_rdy_step"}, 128'(load_rdy), 128'(0));
            end
        end
        @(negedge clk);
        key_load  = 1'b0;
        rk_ready  = 1'b0;
        final_key = '0;
        if (!timed_out) begin
            chk({name, " sched_done"}, 128'(sched_done), 128'(1));
            chk({name, " valid_after"}, 128'(rk_valid), 128'(0));
            chk({name, " load_rdy_after"}, 128'(load_rdy), 128'(1));
            if (pct == 100)
                chk({name, " total_cycles"}, 128'(total + 1), 128'(1 + 10*3 + 1));
            @(negedge clk);
            chk({name, " done_pulse"}, 128'(sched_done), 128'(0));
            chk({name, " still_idle"}, 128'(rk_valid), 128'(0));
        end
    endtask

    logic [127:0] fips_ck;
    logic [127:0] fips_rk10;
    logic [127:0] zero_rk10;
    logic [127:0] rnd_ck;
    int           n;

    initial begin
        fips_ck   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        build_sbox();

        repeat (3) @(negedge clk);
        chk("rst load_rdy", 128'(load_rdy), 128'(1));
        chk("rst rk_valid", 128'(rk_valid), 128'(0));
        chk("rst sched_done", 128'(sched_done), 128'(0));
        chk("rst round_key", round_key, 128'(0));
        chk("rst round_idx", 128'(round_idx), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle rk_valid", 128'(rk_valid), 128'(0));

        build_expected(fips_ck);
        run_sched("fips", to_mat(fips_rk10), 100, 1'b0);

        build_expected(128'h0);
        run_sched("zero", to_mat(zero_rk10), 100, 1'b0);

        build_expected(fips_ck);
        run_sched("bp30", to_mat(fips_rk10), 30, 1'b0);

        rnd_ck = {$urandom, $urandom, $urandom, $urandom};
        build_expected(rnd_ck);
        run_sched("poke", exp_rk[10], 60, 1'b1);

        build_expected(fips_ck);
        @(negedge clk);
        final_key = to_mat(fips_rk10);
        key_load  = 1'b1;
        rk_ready  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            key_load = 1'b0;
            n++;
        end while (!(rk_valid && round_idx == 4'd5) && n < 100);
        chk("mid idx5", 128'(round_idx), 128'(5));
        chk("mid key5", round_key, exp_rk[5]);
        reset    = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
        chk("abort rk_valid", 128'(rk_valid), 128'(0));
        chk("abort round_key", round_key, 128'(0));
        chk("abort load_rdy", 128'(load_rdy), 128'(1));
        chk("abort round_idx", 128'(round_idx), 128'(0));
        reset = 1'b0;
        run_sched("reload", to_mat(fips_rk10), 100, 1'b0);

        for (int k = 0; k < 3; k++) begin
            rnd_ck = {$urandom, $urandom, $urandom, $urandom};
            build_expected(rnd_ck);
            run_sched($sformatf("rnd%0d", k), exp_rk[10], 70, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
